// File: rtl/poly1305_ws.sv
// Word-serial Poly1305 MAC core: one 16-byte block per ld, r multiplied in W-bit digits.
// Accumulator h is kept fully reduced mod 2^130-5 between blocks.
module poly1305_ws #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] r,
  input  logic [127:0] s,
  input  logic [127:0] m,
  input  logic [4:0]   len,
  input  logic         ld,
  input  logic         first,
  input  logic         last,
  output logic [127:0] p,
  output logic         pv,
  output logic         rdy
);

  localparam int unsigned N  = 128 / W;
  localparam int unsigned PW = 131 + W;
  localparam logic [129:0] P_MOD = 130'h3_ffff_ffff_ffff_ffff_ffff_ffff_ffff_fffb;
  localparam logic [127:0] CLAMP = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

  typedef enum logic [2:0] {IDLE, LOAD, MUL, RED, FIN} state_t;

  state_t         state_q, state_d;
  logic [127:0]   rc_q, s_q, m_q;
  logic [4:0]     len_q;
  logic           first_q, last_q;
  logic [130:0]   a_q;
  logic [258:0]   acc_q;
  logic [2:0]     k_q;
  logic           red_q;
  logic [129:0]   h_q;

  logic [128:0]   c_blk;
  logic [W-1:0]   dig;
  logic [PW-1:0]  pp;
  logic [258:0]   acc_fold;
  logic [129:0]   h_red, h_new;
  logic           done;

  // 2^130 == 5 (mod P): fold bits above 130 back in as 5*high.
  function automatic logic [258:0] fold(input logic [258:0] x);
    return 259'(x[129:0]) + 259'({x[258:130], 2'b00}) + 259'(x[258:130]);
  endfunction

  always_comb begin
    c_blk = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < 32'(len_q)) c_blk[8*i +: 8] = m_q[8*i +: 8];
    end
    c_blk[8*32'(len_q)] = 1'b1;
  end

  always_comb begin
    dig      = rc_q[32'(k_q)*W +: W];
    pp       = PW'(a_q) * PW'(dig);
    acc_fold = fold(acc_q);
    // Second fold leaves < 2^130+35, so one conditional subtract fully reduces.
    h_red    = (acc_fold >= 259'(P_MOD)) ? acc_fold[129:0] - P_MOD : acc_fold[129:0];
    h_new    = (state_q == FIN) ? (first_q ? '0 : h_q) : h_red;
    // The second RED cycle also performs the finish step, keeping latency at N+4.
    done     = (state_q == FIN) || ((state_q == RED) && red_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (ld) state_d = LOAD;
      end
      LOAD:    state_d = (len_q == '0) ? FIN : MUL;
      MUL:     if (k_q == 3'(N - 1)) state_d = RED;
      RED:     if (red_q) state_d = IDLE;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rc_q    <= '0;
      s_q     <= '0;
      m_q     <= '0;
      len_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      a_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      red_q   <= 1'b0;
      h_q     <= '0;
      p       <= '0;
      pv      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld) begin
            rc_q    <= r & CLAMP;
            s_q     <= s;
            m_q     <= m;
            len_q   <= (len > 5'd16) ? 5'd16 : len;
            first_q <= first;
            last_q  <= last;
            pv      <= 1'b0;
          end
        end
        LOAD: begin
          a_q   <= (first_q ? '0 : 131'(h_q)) + 131'(c_blk);
          acc_q <= '0;
          k_q   <= '0;
          red_q <= 1'b0;
        end
        MUL: begin
          acc_q <= acc_q + (259'(pp) << (32'(k_q) * W));
          k_q   <= k_q + 3'd1;
        end
        RED: begin
          acc_q <= acc_fold;
          red_q <= 1'b1;
        end
        default: ;
      endcase
      if (done) begin
        h_q <= h_new;
        if (last_q) begin
          p  <= h_new[127:0] + s_q;
          pv <= 1'b1;
        end
      end
    end
  end

endmodule
